// File: rtl/keypad_emulator_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Types and helpers shared by the keypad emulator. The scanner can reuse them
// for its inverse map.
//   state_t    : emulator FSM states
//   key_rc_t   : {row, column} of a key, 0 = top / left
//   key_to_rc  : hex key code -> {row, column} on the 4x4 Pmod keypad
//   ROWS_IDLE  : released value of the active-low row lines
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
    } key_rc_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Physical layout:
    //   1 2 3 A
    //   4 5 6 B
    //   7 8 9 C
    //   0 F E D
    function automatic key_rc_t key_to_rc(input logic [3:0] code);
        key_rc_t rc;
        case (code)
            4'h1:    rc = '{r: 2'd0, c: 2'd0};
            4'h2:    rc = '{r: 2'd0, c: 2'd1};
            4'h3:    rc = '{r: 2'd0, c: 2'd2};
            4'hA:    rc = '{r: 2'd0, c: 2'd3};
            4'h4:    rc = '{r: 2'd1, c: 2'd0};
            4'h5:    rc = '{r: 2'd1, c: 2'd1};
            4'h6:    rc = '{r: 2'd1, c: 2'd2};
            4'hB:    rc = '{r: 2'd1, c: 2'd3};
            4'h7:    rc = '{r: 2'd2, c: 2'd0};
            4'h8:    rc = '{r: 2'd2, c: 2'd1};
            4'h9:    rc = '{r: 2'd2, c: 2'd2};
            4'hC:    rc = '{r: 2'd2, c: 2'd3};
            4'h0:    rc = '{r: 2'd3, c: 2'd0};
            4'hF:    rc = '{r: 2'd3, c: 2'd1};
            4'hE:    rc = '{r: 2'd3, c: 2'd2};
            default: rc = '{r: 2'd3, c: 2'd3}; // 4'hD
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// -----------------------------------------------------------------------------
// keypad_emulator_if
// Key request handshake into the keypad emulator.
//   key_code  : hex key to press, stable while key_valid is high
//   key_valid : request from the producer
//   key_ready : emulator idle; a transfer happens on key_valid & key_ready
// Modports: master = key producer, slave = emulator.
// -----------------------------------------------------------------------------
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/keypad_emulator_row_driver.sv
// -----------------------------------------------------------------------------
// keypad_row_driver
// Registered column-strobe to row-line mapping for one emulated key.
//   clk, rst_n  : clock, asynchronous active-low reset
//   cols        : active-low column strobes from the scanner (cols[3] = left)
//   row_idx     : latched key row, 0 = top
//   col_idx     : latched key column, 0 = left
//   pressed_eff : key currently closed (after optional bounce shaping)
//   rows        : active-low row lines (rows[3] = top), one clk after cols
// Only the latched column bit matters, so a scanner that drives several
// columns low at once still sees the single row of the pressed key.
// -----------------------------------------------------------------------------
module keypad_row_driver
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cols,
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    input  logic       pressed_eff,
    output logic [3:0] rows
);

    logic       col_hit;
    logic [3:0] rows_next;
    logic [3:0] rows_reg;

    assign col_hit = pressed_eff && !cols[2'd3 - col_idx];

    // rows[3-r] is the line of row r; every other line stays released.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign rows_next[gi] = !(col_hit && (row_idx == 2'(3 - gi)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_reg <= ROWS_IDLE;
        end else begin
            rows_reg <= rows_next;
        end
    end

    assign rows = rows_reg;

endmodule

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Drive-side counterpart of the Pmod keypad scanner. Accepts a hex key code
// and emulates a press on a 4x4 keypad: while the key is held, the row line of
// the key is pulled low whenever the scanner strobes the key's column. After
// HOLD_CYCLES the key is released for GAP_CYCLES before the next request is
// accepted.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cols       : active-low column strobes from the scanner (cols[3] = left)
//   key_if     : key request handshake (slave modport)
//   rows       : active-low emulated row lines (rows[3] = top), idle 4'b1111
//   pressed    : key logically pressed
//   busy       : PRESS or GAP in progress
//
// Optional feature, macro KEYPAD_EMU_BOUNCE_EN: for the first BOUNCE_CYCLES of
// a press the effective contact toggles every BOUNCE_PERIOD cycles (starting
// closed) to exercise the scanner's debounce. The pressed port is unaffected.
// -----------------------------------------------------------------------------
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 2_000_000,
    parameter int GAP_CYCLES    = 2_000_000,
    parameter int BOUNCE_CYCLES = 100_000,
    parameter int BOUNCE_PERIOD = 10_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         cols,
    keypad_emulator_if.slave   key_if,
    output logic [3:0]         rows,
    output logic               pressed,
    output logic               busy
);

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 0 || BOUNCE_PERIOD < 1) begin : g_bad_param
        $error("keypad_emulator: HOLD_CYCLES, GAP_CYCLES, BOUNCE_PERIOD must be >= 1");
    end

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       row_reg;
    logic [1:0]       col_reg;
    logic             pressed_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic             handshake;
    logic             pressed_eff;
    key_rc_t          req_rc;

    assign handshake = key_if.key_valid && ready_reg && (state_reg == IDLE);
    assign req_rc    = key_to_rc(key_if.key_code);

    // Counter is loaded with N-1 on entry and checked for zero before every
    // decrement, so each state lasts exactly N cycles and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            pressed_reg <= 1'b0;
            busy_reg    <= 1'b0;
            ready_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        state_reg   <= PRESS;
                        cnt_reg     <= HOLD_LOAD;
                        row_reg     <= req_rc.r;
                        col_reg     <= req_rc.c;
                        pressed_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        ready_reg   <= 1'b0;
                    end
                end
                PRESS: begin
                    if (cnt_reg == '0) begin
                        state_reg   <= GAP;
                        cnt_reg     <= GAP_LOAD;
                        pressed_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                GAP: begin
                    // ready rises on exit, so the next transfer is one cycle later
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    pressed_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    ready_reg   <= 1'b1;
                end
            endcase
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int WIN_W = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int PER_W = $clog2(BOUNCE_PERIOD + 1);
    localparam logic [WIN_W-1:0] WIN_END = WIN_W'(BOUNCE_CYCLES);
    localparam logic [PER_W-1:0] PER_END = PER_W'(BOUNCE_PERIOD - 1);

    logic [WIN_W-1:0] win_cnt_reg;  // cycles into the press, saturates at WIN_END
    logic [PER_W-1:0] per_cnt_reg;  // position inside the current toggle period
    logic             phase_reg;    // contact state during the bounce window

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_reg <= '0;
            per_cnt_reg <= '0;
            phase_reg   <= 1'b0;
        end else if (handshake) begin
            win_cnt_reg <= '0;
            per_cnt_reg <= '0;
            phase_reg   <= 1'b1;
        end else if (state_reg == PRESS) begin
            if (win_cnt_reg != WIN_END) begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
            end
            if (per_cnt_reg == PER_END) begin
                per_cnt_reg <= '0;
                phase_reg   <= ~phase_reg;
            end else begin
                per_cnt_reg <= per_cnt_reg + 1'b1;
            end
        end
    end

    assign pressed_eff = pressed_reg && (phase_reg || (win_cnt_reg == WIN_END));
`else
    assign pressed_eff = pressed_reg;
`endif

    keypad_row_driver u_row_driver (
        .clk         (clk),
        .rst_n       (rst_n),
        .cols        (cols),
        .row_idx     (row_reg),
        .col_idx     (col_reg),
        .pressed_eff (pressed_eff),
        .rows        (rows)
    );

    assign key_if.key_ready = ready_reg;
    assign pressed          = pressed_reg;
    assign busy             = busy_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
// Directed bench for keypad_emulator with HOLD_CYCLES=20, GAP_CYCLES=10,
// BOUNCE_CYCLES=6, BOUNCE_PERIOD=2. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

    localparam int HOLD   = 20;
    localparam int GAP    = 10;
    localparam int BCYC   = 6;
    localparam int BPER   = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       pressed;
    logic       busy;

    int checks;
    int errors;

    keypad_emulator_if key_if ();

    keypad_emulator #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .BOUNCE_CYCLES (BCYC),
        .BOUNCE_PERIOD (BPER)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cols    (cols),
        .key_if  (key_if),
        .rows    (rows),
        .pressed (pressed),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a key at a falling edge, let the next rising edge take it.
    task automatic press_key(input logic [3:0] code);
        key_if.key_code  = code;
        key_if.key_valid = 1'b1;
        checks++;
        if (key_if.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_ready key %h: key_ready=%b required 1", code, key_if.key_ready);
        end
        tick();
        key_if.key_valid = 1'b0;
        $display("press key %h: pressed=%b busy=%b", code, pressed, busy);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (key_if.key_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (key_if.key_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: key_ready=%b busy=%b required 1/0 after %0d cycles",
                     key_if.key_ready, busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        cols             = 4'b1111;
        key_if.key_code  = 4'h0;
        key_if.key_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if ({rows, pressed, busy, key_if.key_ready} !== {4'b1111, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: rows=%b pressed=%b busy=%b ready=%b required 1111/0/0/1",
                     rows, pressed, busy, key_if.key_ready);
        end
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a key 5 press
        press_key(4'h5);
        cols = 4'b1011;
        repeat (3) tick();
        checks++;
        if (rows !== 4'b1011) begin
            errors++;
            $display("FAIL reset_pre_rows: rows=%b required 1011", rows);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rows, pressed, busy, key_if.key_ready} !== {4'b1111, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async: rows=%b pressed=%b busy=%b ready=%b required 1111/0/0/1",
                     rows, pressed, busy, key_if.key_ready);
        end
        $display("async reset mid-press: rows=%b pressed=%b", rows, pressed);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if ({rows, pressed} !== {4'b1111, 1'b0}) begin
                errors++;
                $display("FAIL reset_no_resume cycle %0d: rows=%b pressed=%b required 1111/0",
                         i, rows, pressed);
            end
        end
        cols = 4'b1111;
    endtask

    task automatic test_key5_scan();
        logic [3:0] pat [4];
        int pcount;
        logic [3:0] exp_rows;
        pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
        press_key(4'h5);
        pcount = (pressed === 1'b1) ? 1 : 0;
        for (int i = 0; i < 16; i++) begin
            cols = pat[i % 4];
            tick();
            exp_rows = (pat[i % 4] == 4'b1011) ? 4'b1011 : 4'b1111;
            checks++;
            if (rows !== exp_rows) begin
                errors++;
                $display("FAIL key5_scan cols=%b: rows=%b required %b", pat[i % 4], rows, exp_rows);
            end
            if (pressed === 1'b1) pcount++;
        end
        cols = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pressed === 1'b1) pcount++;
        end
        checks++;
        if (pcount != HOLD) begin
            errors++;
            $display("FAIL key5_hold_len: pressed cycles=%0d required %0d", pcount, HOLD);
        end
        $display("key 5 scan done: pressed cycles=%0d", pcount);
        wait_idle();
    endtask

    task automatic test_corner_keys();
        logic [3:0] code_t [3];
        logic [3:0] cols_t [3];
        logic [3:0] rows_t [3];
        code_t[0] = 4'hD; cols_t[0] = 4'b1110; rows_t[0] = 4'b1110;
        code_t[1] = 4'hA; cols_t[1] = 4'b1110; rows_t[1] = 4'b0111;
        code_t[2] = 4'h0; cols_t[2] = 4'b0111; rows_t[2] = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            press_key(code_t[k]);
            cols = cols_t[k];
            tick();
            checks++;
            if (rows !== rows_t[k]) begin
                errors++;
                $display("FAIL corner_key %h cols=%b: rows=%b required %b",
                         code_t[k], cols_t[k], rows, rows_t[k]);
            end
            cols = 4'b1111;
            tick();
            wait_idle();
        end
    endtask

    task automatic test_back_to_back();
        int low_cnt;
        key_if.key_code  = 4'h1;
        key_if.key_valid = 1'b1;
        checks++;
        if (key_if.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_first: key_ready=%b required 1", key_if.key_ready);
        end
        tick();
        // key 1 is row 0, column 0
        key_if.key_code = 4'h2;
        cols = 4'b0111;
        low_cnt = (key_if.key_ready === 1'b0) ? 1 : 0;
        tick();
        checks++;
        if (rows !== 4'b0111) begin
            errors++;
            $display("FAIL b2b_code_change: rows=%b required 0111", rows);
        end
        if (key_if.key_ready === 1'b0) low_cnt++;
        while (key_if.key_ready !== 1'b1 && low_cnt < 100) begin
            tick();
            if (key_if.key_ready === 1'b0) low_cnt++;
        end
        checks++;
        if (low_cnt != HOLD + GAP) begin
            errors++;
            $display("FAIL b2b_ready_low: low cycles=%0d required %0d", low_cnt, HOLD + GAP);
        end
        checks++;
        if (pressed !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap_end: pressed=%b required 0", pressed);
        end
        tick();
        key_if.key_valid = 1'b0;
        checks++;
        if ({pressed, key_if.key_ready} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_second_xfer: pressed=%b ready=%b required 1/0", pressed, key_if.key_ready);
        end
        // second key latched as 2: column 0 no longer answers, column 1 does
        cols = 4'b0111;
        tick();
        checks++;
        if (rows !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_key2_col0: rows=%b required 1111", rows);
        end
        cols = 4'b1011;
        tick();
        checks++;
        if (rows !== 4'b0111) begin
            errors++;
            $display("FAIL b2b_key2_col1: rows=%b required 0111", rows);
        end
        $display("back-to-back: ready low %0d cycles, second key rows=%b", low_cnt, rows);
        cols = 4'b1111;
        wait_idle();
    endtask

    task automatic test_multi_cols();
        logic [3:0] cols_t [4];
        logic [3:0] rows_t [4];
        cols_t[0] = 4'b0000; rows_t[0] = 4'b1101;
        cols_t[1] = 4'b1111; rows_t[1] = 4'b1111;
        cols_t[2] = 4'b1100; rows_t[2] = 4'b1101;
        cols_t[3] = 4'b0011; rows_t[3] = 4'b1111;
        press_key(4'h9);
        for (int k = 0; k < 4; k++) begin
            cols = cols_t[k];
            tick();
            checks++;
            if (rows !== rows_t[k]) begin
                errors++;
                $display("FAIL multi_cols key 9 cols=%b: rows=%b required %b", cols_t[k], rows, rows_t[k]);
            end
        end
        cols = 4'b1111;
        wait_idle();
    endtask

    task automatic test_bounce();
        logic [3:0] exp_rows [HOLD];
        for (int j = 0; j < HOLD; j++) exp_rows[j] = 4'b1101;
`ifdef KEYPAD_EMU_BOUNCE_EN
        exp_rows[2] = 4'b1111;
        exp_rows[3] = 4'b1111;
`endif
        press_key(4'h8);
        cols = 4'b1011;
        for (int j = 0; j < HOLD; j++) begin
            tick();
            checks++;
            if (rows !== exp_rows[j]) begin
                errors++;
                $display("FAIL bounce_rows cycle %0d: rows=%b required %b", j, rows, exp_rows[j]);
            end
            if (j < HOLD - 1) begin
                checks++;
                if (pressed !== 1'b1) begin
                    errors++;
                    $display("FAIL bounce_pressed cycle %0d: pressed=%b required 1", j, pressed);
                end
            end
        end
        tick();
        checks++;
        if ({rows, pressed} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL bounce_release: rows=%b pressed=%b required 1111/0", rows, pressed);
        end
        $display("key 8 press with column held: release rows=%b", rows);
        cols = 4'b1111;
        wait_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_key5_scan();
        test_corner_keys();
        test_back_to_back();
        test_multi_cols();
        test_bounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
